cpu_seq_ctrl: RTL

//  Instruction sequencer for the 8-bit mini CPU. Walks a state machine per instruction:
//  two-byte fetch, decode, optional operand read or store. Drives the PC, IR, accumulator,

---
 rtl/cpu_seq_ctrl_if.sv | 31 +++
 rtl/cpu_seq_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl_if.sv
// Control bundle between the mini-CPU sequencer (master) and its IR/PC/ACC/memory/ALU datapath (slave).
// Purely combinational wiring; handshake is the memory mem_rdy completion strobe.
interface cpu_seq_ctrl_if;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rdy;
    logic       rd;
    logic       wr;
    logic       load_ir_hi;
    logic       load_ir_lo;
    logic       inc_pc;
    logic       load_pc;
    logic       alu_stb;
    logic       load_acc;
    logic       datactl_ena;
    logic       halt;
    logic [2:0] state_dbg;

    modport master (
        input  ena, opcode, zero, mem_rdy,
        output rd, wr, load_ir_hi, load_ir_lo, inc_pc, load_pc,
               alu_stb, load_acc, datactl_ena, halt, state_dbg
    );

    modport slave (
        output ena, opcode, zero, mem_rdy,
        input  rd, wr, load_ir_hi, load_ir_lo, inc_pc, load_pc,
               alu_stb, load_acc, datactl_ena, halt, state_dbg
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Per-instruction sequencer: 2-byte fetch, decode, then operand read / store / skip; 3-5 cycles per instruction.
// Memory stalls via mem_rdy=0 hold state and strobes; ena=0 freezes state and zeroes strobes.
module cpu_seq_ctrl (
    input  logic           clk_i,
    input  logic           rst_i,
    cpu_seq_ctrl_if.master seq_io
);
    localparam logic [2:0] OP_HLT  = 3'd0;
    localparam logic [2:0] OP_SKZ  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_ANDD = 3'd3;
    localparam logic [2:0] OP_XORR = 3'd4;
    localparam logic [2:0] OP_LDA  = 3'd5;
    localparam logic [2:0] OP_STO  = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH_HI = 3'd0,
        S_FETCH_LO = 3'd1,
        S_DECODE   = 3'd2,
        S_OPRD     = 3'd3,
        S_ACC      = 3'd4,
        S_STORE    = 3'd5,
        S_SKIP     = 3'd6,
        S_HALTED   = 3'd7
    } state_e;

    state_e state_q, state_d;
    logic   skip_cnt_q, skip_cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH_HI;
            skip_cnt_q <= 1'b0;
        end else if (seq_io.ena) begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        case (state_q)
            S_FETCH_HI: if (seq_io.mem_rdy) state_d = S_FETCH_LO;
            S_FETCH_LO: if (seq_io.mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                // Unknown or undriven opcodes park the CPU rather than run garbage.
                case (seq_io.opcode)
                    OP_HLT:                          state_d = S_HALTED;
                    OP_JMP:                          state_d = S_FETCH_HI;
                    OP_SKZ:                          state_d = seq_io.zero ? S_SKIP : S_FETCH_HI;
                    OP_ADD, OP_ANDD, OP_XORR, OP_LDA: state_d = S_OPRD;
                    OP_STO:                          state_d = S_STORE;
                    default:                         state_d = S_HALTED;
                endcase
            end
            S_OPRD:  if (seq_io.mem_rdy) state_d = S_ACC;
            S_ACC:   state_d = S_FETCH_HI;
            S_STORE: if (seq_io.mem_rdy) state_d = S_FETCH_HI;
            S_SKIP: begin
                if (skip_cnt_q) begin
                    state_d    = S_FETCH_HI;
                    skip_cnt_d = 1'b0;
                end else begin
                    skip_cnt_d = 1'b1;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_HALTED;
        endcase
    end

    always_comb begin
        seq_io.rd          = 1'b0;
        seq_io.wr          = 1'b0;
        seq_io.load_ir_hi  = 1'b0;
        seq_io.load_ir_lo  = 1'b0;
        seq_io.inc_pc      = 1'b0;
        seq_io.load_pc     = 1'b0;
        seq_io.alu_stb     = 1'b0;
        seq_io.load_acc    = 1'b0;
        seq_io.datactl_ena = 1'b0;
        seq_io.halt        = 1'b0;
        seq_io.state_dbg   = 3'd0;
        if (!rst_i) begin
            seq_io.halt      = (state_q == S_HALTED);
            seq_io.state_dbg = state_q;
        end
        // Strobes only fire when the sequencer is actually allowed to advance.
        if (!rst_i && seq_io.ena) begin
            case (state_q)
                S_FETCH_HI: begin
                    seq_io.rd         = 1'b1;
                    seq_io.load_ir_hi = seq_io.mem_rdy;
                    seq_io.inc_pc     = seq_io.mem_rdy;
                end
                S_FETCH_LO: begin
                    seq_io.rd         = 1'b1;
                    seq_io.load_ir_lo = seq_io.mem_rdy;
                    seq_io.inc_pc     = seq_io.mem_rdy;
                end
                S_DECODE: seq_io.load_pc = (seq_io.opcode == OP_JMP);
                S_OPRD: begin
                    seq_io.rd      = 1'b1;
                    seq_io.alu_stb = seq_io.mem_rdy;
                end
                S_ACC: seq_io.load_acc = 1'b1;
                S_STORE: begin
                    seq_io.wr          = 1'b1;
                    seq_io.datactl_ena = 1'b1;
                end
                S_SKIP:  seq_io.inc_pc = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
